// File: rtl/sys_gpio_a_port.sv
// GPIO port A pad stage: output data register, pad enables, input
// synchroniser, edge capture with maskable interrupt, Avalon-MM slave.
module sys_gpio_a_port #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_OUT   = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata,
    input  logic [DATA_WIDTH-1:0] dir_in,
    input  logic [DATA_WIDTH-1:0] pad_in,
    output logic [DATA_WIDTH-1:0] pad_out,
    output logic [DATA_WIDTH-1:0] pad_oe,
    output logic                  irq
);

    localparam logic [0:0] UNARMED = 1'b0;
    localparam logic [0:0] ARMED   = 1'b1;

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_RISE   = 3'd1;
    localparam logic [2:0] A_MASK   = 3'd2;
    localparam logic [2:0] A_EDGE   = 3'd3;
    localparam logic [2:0] A_OUTSET = 3'd4;
    localparam logic [2:0] A_OUTCLR = 3'd5;
    localparam logic [2:0] A_FALL   = 3'd6;
    localparam logic [2:0] A_PINRAW = 3'd7;

    localparam logic [2:0] ARM_LAST = 3'(SYNC_STAGES);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] rise_q, rise_d;
    logic [DATA_WIDTH-1:0] fall_q, fall_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] sync_in;
    logic [DATA_WIDTH-1:0] ev_rise, ev_fall;
    logic [0:0]            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  armed;
    logic                  wr;
    logic                  wr_data, wr_rise, wr_mask, wr_edge;
    logic                  wr_set, wr_clr, wr_fall;

    assign wr      = chipselect & ~write_n;
    assign wr_data = wr && (address == A_DATA);
    assign wr_rise = wr && (address == A_RISE);
    assign wr_mask = wr && (address == A_MASK);
    assign wr_edge = wr && (address == A_EDGE);
    assign wr_set  = wr && (address == A_OUTSET);
    assign wr_clr  = wr && (address == A_OUTCLR);
    assign wr_fall = wr && (address == A_FALL);

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign armed   = (state_q == ARMED);
    assign pad_oe  = dir_in;
    assign pad_out = data_q;
    assign irq     = |(cap_q & mask_q);

    assign ev_rise = sync_in & ~prev_q & rise_q & ~dir_in
                   & {DATA_WIDTH{armed}};
    assign ev_fall = ~sync_in & prev_q & fall_q & ~dir_in
                   & {DATA_WIDTH{armed}};

    always_comb begin
        data_d = data_q;
        unique case (1'b1)
            wr_data: data_d = writedata;
            wr_set:  data_d = data_q | writedata;
            wr_clr:  data_d = data_q & ~writedata;
            default: data_d = data_q;
        endcase
    end

    always_comb begin
        rise_d = wr_rise ? writedata : rise_q;
        fall_d = wr_fall ? writedata : fall_q;
        mask_d = wr_mask ? writedata : mask_q;
        // A new event outranks a simultaneous write-1-to-clear
        cap_d  = (cap_q & ~(writedata & {DATA_WIDTH{wr_edge}}))
               | ev_rise | ev_fall;
    end

    // Hold off capture until the synchroniser has flushed its reset zeros
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == UNARMED) begin
            if (cnt_q == ARM_LAST) begin
                state_d = ARMED;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            A_DATA:   readdata = (data_q & dir_in) | (sync_in & ~dir_in);
            A_RISE:   readdata = rise_q;
            A_MASK:   readdata = mask_q;
            A_EDGE:   readdata = cap_q;
            A_OUTSET: readdata = '0;
            A_OUTCLR: readdata = '0;
            A_FALL:   readdata = fall_q;
            A_PINRAW: readdata = sync_in;
            default:  readdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pad_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= RESET_OUT;
            rise_q  <= '0;
            fall_q  <= '0;
            mask_q  <= '0;
            cap_q   <= '0;
            prev_q  <= '0;
            state_q <= UNARMED;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            prev_q  <= sync_in;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sys_gpio_a_port.sv
// Directed bench for sys_gpio_a_port: register-map vector table plus
// hand-written sequences for edge capture, W1C races and reset.
module tb_sys_gpio_a_port;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] dir_in;
    logic [31:0] pad_in;
    logic [31:0] pad_out;
    logic [31:0] pad_oe;
    logic        irq;

    int n_chk;
    int n_fail;

    sys_gpio_a_port dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .dir_in     (dir_in),
        .pad_in     (pad_in),
        .pad_out    (pad_out),
        .pad_oe     (pad_oe),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        wr;
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] dir;
        logic [31:0] pad;
        logic [2:0]  raddr;
        logic [31:0] exp_rd;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    logic [31:0] r;

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        dir_in     = '0;
        pad_in     = 32'hFFFF_FFFF;

        vecs[0] = '{1'b1, 3'd0, 32'h12345678, 32'h0000FFFF, 32'hABCD0000,
                    3'd0, 32'hABCD5678, 32'h12345678};
        vecs[1] = '{1'b0, 3'd0, 32'h0, 32'h0000FFFF, 32'hABCD0000,
                    3'd7, 32'hABCD0000, 32'h12345678};
        vecs[2] = '{1'b1, 3'd0, 32'h000000F0, 32'hFFFFFFFF, 32'hABCD0000,
                    3'd0, 32'h000000F0, 32'h000000F0};
        vecs[3] = '{1'b1, 3'd4, 32'h0000000F, 32'hFFFFFFFF, 32'hABCD0000,
                    3'd4, 32'h0, 32'h000000FF};
        vecs[4] = '{1'b1, 3'd5, 32'h00000030, 32'hFFFFFFFF, 32'hABCD0000,
                    3'd5, 32'h0, 32'h000000CF};
        vecs[5] = '{1'b1, 3'd1, 32'h0000A5A5, 32'hFFFFFFFF, 32'hABCD0000,
                    3'd1, 32'h0000A5A5, 32'h000000CF};
        vecs[6] = '{1'b1, 3'd6, 32'h00005A5A, 32'hFFFFFFFF, 32'hABCD0000,
                    3'd6, 32'h00005A5A, 32'h000000CF};
        vecs[7] = '{1'b1, 3'd2, 32'h0000F0F0, 32'hFFFFFFFF, 32'hABCD0000,
                    3'd2, 32'h0000F0F0, 32'h000000CF};
        vecs[8] = '{1'b1, 3'd7, 32'h0000FFFF, 32'hFFFFFFFF, 32'h0F0F0000,
                    3'd7, 32'h0F0F0000, 32'h000000CF};
        vecs[9] = '{1'b0, 3'd0, 32'h0, 32'hFFFFFFFF, 32'h0F0F0000,
                    3'd3, 32'h0, 32'h000000CF};

        // reset with all-ones pads; enable rise capture right away
        tick(3);
        reset_n = 1'b1;
        wr(3'd1, 32'hFFFF_FFFF);
        tick(20);
        rd(3'd3, r);
        chk("reset_edgecap", r, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        chk("reset_pad_out", pad_out, 32'h0);
        chk("reset_pad_oe", pad_oe, 32'h0);
        wr(3'd1, 32'h0);

        for (int i = 0; i < 10; i++) begin
            dir_in = vecs[i].dir;
            pad_in = vecs[i].pad;
            if (vecs[i].wr) wr(vecs[i].waddr, vecs[i].wdata);
            tick(3);
            rd(vecs[i].raddr, r);
            chk($sformatf("vec%0d_rd", i), r, vecs[i].exp_rd);
            chk($sformatf("vec%0d_out", i), pad_out, vecs[i].exp_out);
            chk($sformatf("vec%0d_oe", i), pad_oe, vecs[i].dir);
            chk($sformatf("vec%0d_irq", i), {31'b0, irq}, 32'h0);
        end

        // rising edge on bit 0 -> capture after 3 edges, irq
        wr(3'd1, 32'h1);
        wr(3'd6, 32'h0);
        wr(3'd2, 32'h1);
        pad_in = 32'h0;
        dir_in = 32'h0;
        tick(5);
        wr(3'd3, 32'hFFFF_FFFF);
        rd(3'd3, r);
        chk("pre_rise_cap", r, 32'h0);
        pad_in = 32'h1;
        tick(2);
        chk("rise_irq_2edges", {31'b0, irq}, 32'h0);
        tick(1);
        rd(3'd3, r);
        chk("rise_cap_3edges", r, 32'h1);
        chk("rise_irq_3edges", {31'b0, irq}, 32'h1);
        pad_in = 32'h0;
        tick(5);
        rd(3'd3, r);
        chk("fall_disabled", r, 32'h1);
        wr(3'd3, 32'h1);
        chk("w1c_irq_drop", {31'b0, irq}, 32'h0);

        // W1C racing a fall event on bit 3: event wins
        wr(3'd6, 32'h8);
        pad_in = 32'h8;
        tick(5);
        wr(3'd3, 32'hFFFF_FFFF);
        pad_in = 32'h0;
        tick(2);
        wr(3'd3, 32'h8);
        rd(3'd3, r);
        chk("w1c_race_cap", r, 32'h8);
        wr(3'd3, 32'h8);
        rd(3'd3, r);
        chk("w1c_plain_clear", r, 32'h0);

        // output-direction bit ignores toggles, input bit captures
        wr(3'd1, 32'h20);
        wr(3'd6, 32'h20);
        dir_in = 32'h20;
        pad_in = 32'h20;
        tick(4);
        pad_in = 32'h0;
        tick(4);
        rd(3'd3, r);
        chk("dir_out_no_cap", r, 32'h0);
        dir_in = 32'h0;
        tick(2);
        pad_in = 32'h20;
        tick(4);
        rd(3'd3, r);
        chk("dir_in_cap", r, 32'h20);
        dir_in = 32'h20;
        tick(2);
        rd(3'd3, r);
        chk("dir_switch_retain", r, 32'h20);
        wr(3'd2, 32'h20);
        chk("irq_masked_on", {31'b0, irq}, 32'h1);
        wr(3'd0, 32'hDEADBEEF);
        chk("data_before_rst", pad_out, 32'hDEADBEEF);

        // asynchronous reset between clock edges
        #2;
        reset_n = 1'b0;
        dir_in  = 32'h0;
        #1;
        chk("async_rst_out", pad_out, 32'h0);
        chk("async_rst_irq", {31'b0, irq}, 32'h0);
        chk("async_rst_oe", pad_oe, 32'h0);
        rd(3'd3, r);
        chk("async_rst_cap", r, 32'h0);
        rd(3'd1, r);
        chk("async_rst_rise", r, 32'h0);
        tick(2);
        reset_n = 1'b1;
        wr(3'd1, 32'h20);
        tick(10);
        rd(3'd3, r);
        chk("rearm_no_false_edge", r, 32'h0);
        rd(3'd7, r);
        chk("rearm_pin_raw", r, 32'h20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_gpio_a_port.md
# sys_gpio_a_port

GPIO port A pad stage, the downstream consumer of the port-A direction register output. Holds the port-A output data register, drives the pad output enables from the direction vector, synchronises pad inputs, and captures input edges into a sticky register with a maskable interrupt. It is an Avalon-MM slave on the system interconnect with zero wait states and zero read latency.

## Interface
- DATA_WIDTH, 32: pad count; all data, mask and edge registers are this width.
- SYNC_STAGES, 2: input synchroniser depth; legal values 2–4.
- RESET_OUT, 0: reset value of the output data register.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  DATA_WIDTH  write data.
- readdata  out  DATA_WIDTH  read data, combinational from address.
- dir_in  in  DATA_WIDTH  per-bit direction from the port-A direction register; 1 = output.
- pad_in  in  DATA_WIDTH  raw, asynchronous pad input.
- pad_out  out  DATA_WIDTH  output data register contents.
- pad_oe  out  DATA_WIDTH  pad output enable, equal to dir_in (pass-through).
- irq  out  1  level interrupt, active high.

## Operation
Write strobe is chipselect && !write_n. Register map:
- 0 DATA:
  - Write: sets data_out.
  - Read: (data_out & dir_in) | (sync_in & ~dir_in).
- 1 RISE_EN: R/W; per-bit rising-edge capture enable.
- 2 IRQ_MASK: R/W; per-bit interrupt enable.
- 3 EDGE_CAP:
  - Read returns the capture bits.
  - Write-1-to-clear; write-0 bits are unaffected.
- 4 OUTSET: write: data_out |= writedata. Reads 0.
- 5 OUTCLR: write: data_out &= ~writedata. Reads 0.
- 6 FALL_EN: R/W; per-bit falling-edge capture enable.
- 7 PIN_RAW: read-only; returns sync_in for all bits regardless of direction. Writes are ignored.

Input path:
- pad_in passes through a SYNC_STAGES flip-flop chain to produce sync_in.
- prev_in registers sync_in every cycle, independent of direction.
- A rise event is sync_in & ~prev_in & RISE_EN & ~dir_in & armed.
- A fall event is ~sync_in & prev_in & FALL_EN & ~dir_in & armed.
- An event sets the corresponding EDGE_CAP bit.

Arming counter:
- After reset deassertion the counter counts SYNC_STAGES+1 clocks, then asserts armed and holds it.
- While unarmed no capture occurs. This suppresses false edges from the synchroniser's all-zero reset state.
- States: UNARMED (counting) and ARMED. Only reset leaves ARMED.

Interrupt: irq = |(EDGE_CAP & IRQ_MASK), taken from registered values only.

Reset values:
- data_out = RESET_OUT.
- RISE_EN, FALL_EN, IRQ_MASK, EDGE_CAP, sync chain, prev_in all 0.
- armed = 0; irq = 0.
- pad_oe follows dir_in (0 while the upstream register is in reset).

Boundary rules:
- Simultaneous W1C and new event on the same bit: the event wins and the bit stays 1.
- A bit switching input to output stops new captures immediately. Its existing EDGE_CAP bit is retained.
- A bit switching output to input may capture from the next cycle.
- Reset mid-operation clears all state asynchronously and restarts the arming count.
- Unmapped behaviour: none. All 8 addresses are defined.

## Timing
- Write effect visible on pad_out and register reads the cycle after the write edge.
- pad_oe has zero latency from dir_in.
- pad_in to sync_in: SYNC_STAGES clock edges; plus 1 edge to EDGE_CAP; irq asserts combinationally from that register.
  - Total pad_in to irq with the default of 2: 3 rising edges.
- W1C of the last masked set bit: irq deasserts the cycle after the write edge.
- readdata is valid in the same cycle as address/chipselect (read latency 0, no wait states).

## Test plan
- Reset with pad_in = all-ones, RISE_EN written to 0xFFFFFFFF in the first cycle after reset, 20 cycles idle -> EDGE_CAP = 0, irq = 0, pad_out = RESET_OUT.
- dir_in = 0x0000FFFF; write DATA = 0x12345678; pad_in = 0xABCD0000 -> pad_out = 0x12345678, pad_oe = 0x0000FFFF, DATA read = 0xABCD5678.
- DATA = 0x000000F0, OUTSET 0x0F, then OUTCLR 0x30 -> pad_out 0xFF, then 0xCF; OUTSET/OUTCLR reads return 0.
- Input pins, RISE_EN = 0x1, IRQ_MASK = 0x1, pad_in[0] 0->1 -> EDGE_CAP = 0x1 after 3 edges and irq = 1. A falling edge with FALL_EN = 0 produces no change. W1C of 0x1 drops irq the next cycle.
- W1C of bit 3 issued in the same cycle as a bit-3 fall event (FALL_EN[3] = 1) -> EDGE_CAP[3] remains 1.
- Capture armed, dir_in[5] = 1, toggle pad_in[5] -> no capture. Clear dir_in[5], toggle -> EDGE_CAP[5] = 1. Assert reset_n = 0 mid-stream -> all outputs return to their reset values asynchronously.
